// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multicycle MIPS subset core with a single request/ready memory port
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          WAIT_MAX = 255
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic [1:0]        fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [1:0] F_NONE = 2'd0, F_ILLEGAL = 2'd1, F_TIMEOUT = 2'd2, F_MISALIGN = 2'd3;
  localparam logic [31:0] WAIT_LAST = (WAIT_MAX > 0) ? 32'(WAIT_MAX - 1) : 32'd0;

  state_t            r_state, w_next;
  logic [1:0]        r_fault, w_fault_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir, r_a, r_b, r_imm, r_aluout, r_mdr, r_wait;
  logic [31:0]       r_regs [32];

  logic [5:0]        w_op, w_funct;
  logic [4:0]        w_rs, w_rt, w_rd;
  logic              w_legal, w_is_mem, w_wait_last;
  logic [31:0]       w_alu, w_pc32, w_br32, w_j32;
  logic              w_req, w_we;
  logic [ADDR_W-1:0] w_addr;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];

  assign w_legal = (w_op == OP_RTYPE) ?
                   ((w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                    (w_funct == FN_OR) || (w_funct == FN_SLT)) :
                   ((w_op == OP_ADDI) || (w_op == OP_LW) || (w_op == OP_SW) ||
                    (w_op == OP_BEQ) || (w_op == OP_J));
  assign w_is_mem    = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_wait_last = (WAIT_MAX > 0) && (r_wait == WAIT_LAST);

  // pc is already pc+4 when EXEC runs, so both targets are relative to the next instruction
  assign w_pc32 = 32'(r_pc);
  assign w_br32 = w_pc32 + {r_imm[29:0], 2'b00};
  assign w_j32  = {w_pc32[31:28], r_ir[25:0], 2'b00};

  // ALU: R-type function select, otherwise base + immediate for addi/lw/sw
  always_comb begin
    w_alu = r_a + r_imm;
    if (w_op == OP_RTYPE) begin
      case (w_funct)
        FN_ADD:  w_alu = r_a + r_b;
        FN_SUB:  w_alu = r_a - r_b;
        FN_AND:  w_alu = r_a & r_b;
        FN_OR:   w_alu = r_a | r_b;
        FN_SLT:  w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
        default: w_alu = r_a + r_b;
      endcase
    end
  end

  // Next-state, fault cause and memory port drive
  always_comb begin
    w_next       = r_state;
    w_fault_next = r_fault;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = r_pc;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_wait_last) begin
          w_next       = S_HALT;
          w_fault_next = F_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next       = S_HALT;
          w_fault_next = F_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (w_is_mem) begin
          if (w_alu[1:0] != 2'b00) begin
            w_next       = S_HALT;
            w_fault_next = F_MISALIGN;
          end else begin
            w_next = S_MEM;
          end
        end else if ((w_op == OP_BEQ) || (w_op == OP_J)) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_req  = 1'b1;
        w_we   = (w_op == OP_SW);
        w_addr = r_aluout[ADDR_W-1:0];
        if (mem_ready) begin
          w_next = (w_op == OP_SW) ? S_FETCH : S_WB;
        end else if (w_wait_last) begin
          w_next       = S_HALT;
          w_fault_next = F_TIMEOUT;
        end
      end
      S_WB:    w_next = S_FETCH;
      default: w_next = S_HALT;
    endcase
  end

  // State and fault registers; HALT only leaves through reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_fault <= F_NONE;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault_next;
    end
  end

  // Datapath: IR/pc on fetch, operand latch, ALU result, MDR and register write-back
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc     <= RESET_PC[ADDR_W-1:0];
      r_ir     <= 32'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_imm    <= 32'd0;
      r_aluout <= 32'd0;
      r_mdr    <= 32'd0;
      r_wait   <= 32'd0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      if (w_req && !mem_ready) r_wait <= r_wait + 32'd1;
      else                     r_wait <= 32'd0;
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + ADDR_W'(4);
          end
        end
        S_DECODE: begin
          r_a   <= r_regs[w_rs];
          r_b   <= r_regs[w_rt];
          r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
        end
        S_EXEC: begin
          r_aluout <= w_alu;
          if ((w_op == OP_BEQ) && (r_a == r_b)) r_pc <= w_br32[ADDR_W-1:0];
          if (w_op == OP_J)                      r_pc <= w_j32[ADDR_W-1:0];
        end
        S_MEM: begin
          if (mem_ready && (w_op == OP_LW)) r_mdr <= mem_rdata;
        end
        S_WB: begin
          if (w_op == OP_RTYPE) begin
            if (w_rd != 5'd0) r_regs[w_rd] <= r_aluout;
          end else if (w_rt != 5'd0) begin
            r_regs[w_rt] <= (w_op == OP_LW) ? r_mdr : r_aluout;
          end
        end
        default: ;
      endcase
    end
  end

  // Requests are masked during reset so an interrupted store can never complete
  assign mem_req   = w_req & ~reset;
  assign mem_we    = w_we & ~reset;
  assign mem_addr  = w_addr;
  assign mem_wdata = r_b;
  assign pc        = r_pc;
  assign state     = r_state;
  assign halted    = (r_state == S_HALT);
  assign fault     = r_fault;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - self-checking bench for mips_multicycle_core
module tb_mips_multicycle_core;

  localparam int WAIT_MAX = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [2:0]  state;
  logic [1:0]  fault;

  logic [31:0] mem [256];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [256];

  int          n_tests = 0;
  int          n_fail = 0;
  int          wr_count, req_cycles, low_streak;
  logic [31:0] wr_addr, wr_data;
  bit          rand_ready;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          cycles;
    logic [31:0] pc_after;
    int          reg_idx;
    logic [31:0] reg_val;
  } vec_t;
  vec_t vecs[$];

  mips_multicycle_core #(
    .RESET_PC(32'h0000_0000),
    .ADDR_W  (32),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc       (pc),
    .state    (state),
    .halted   (halted),
    .fault    (fault)
  );

  // Free-running clock
  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr[9:2]];

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int tgt);
    return {6'h02, 26'(tgt)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] ins, input int cyc,
                         input logic [31:0] pca, input int ri, input logic [31:0] rv);
    vec_t v;
    v.addr = a; v.instr = ins; v.cycles = cyc; v.pc_after = pca; v.reg_idx = ri; v.reg_val = rv;
    vecs.push_back(v);
  endtask

  // One clock: service a store at the coming edge, then sample 1 time unit after it
  task automatic tick();
    #1;
    if (mem_req && mem_ready && mem_we) begin
      mem[mem_addr[9:2]] = mem_wdata;
      wr_count++;
      wr_addr = mem_addr;
      wr_data = mem_wdata;
    end
    if (mem_req) req_cycles++;
    @(posedge clock);
    #1;
    if (rand_ready) begin
      if (low_streak >= 2 || $urandom_range(0, 2) != 0) begin
        mem_ready  = 1'b1;
        low_streak = 0;
      end else begin
        mem_ready = 1'b0;
        low_streak++;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    mem_ready  = 1'b1;
    rand_ready = 1'b0;
    low_streak = 0;
    tick();
    check("rst_req_low", {31'd0, mem_req}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_halt_fault", {29'd0, halted, fault}, 32'd0);
    check("rst_req_rise", {31'd0, mem_req}, 32'd1);
    wr_count   = 0;
    req_cycles = 0;
  endtask

  task automatic run_instr(output int cyc);
    cyc = 0;
    tick();
    cyc++;
    while (state != 3'd0 && state != 3'd7 && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_random(input int n);
    int          kind, rs, rt, rd, imm, k, cnt;
    logic [31:0] a, b, v, ins;
    logic [5:0]  fn;
    clear_mem();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    for (int i = 128; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 7);
      rs   = $urandom_range(0, 7);
      rt   = $urandom_range(0, 7);
      rd   = $urandom_range(0, 7);
      a    = m_reg[rs];
      b    = m_reg[rt];
      if (kind <= 4) begin
        case (kind)
          0:       begin fn = 6'h20; v = a + b; end
          1:       begin fn = 6'h22; v = a - b; end
          2:       begin fn = 6'h24; v = a & b; end
          3:       begin fn = 6'h25; v = a | b; end
          default: begin fn = 6'h2A; v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        endcase
        ins = enc_r(int'(fn), rs, rt, rd);
        if (rd != 0) m_reg[rd] = v;
      end else if (kind == 5) begin
        imm = $urandom_range(0, 65535);
        ins = enc_i('h08, rs, rt, imm);
        if (rt != 0) m_reg[rt] = a + {{16{imm[15]}}, imm[15:0]};
      end else begin
        k = $urandom_range(0, 31);
        if (kind == 6) begin
          ins = enc_i('h23, 0, rt, 'h200 + 4 * k);
          if (rt != 0) m_reg[rt] = m_mem[128 + k];
        end else begin
          ins = enc_i('h2B, 0, rt, 'h200 + 4 * k);
          m_mem[128 + k] = b;
        end
      end
      mem[i] = ins;
    end
    mem[n] = 32'hFC00_0000;
    do_reset();
    rand_ready = 1'b1;
    cnt = 0;
    while (!halted && cnt < 3000) begin
      tick();
      cnt++;
    end
    rand_ready = 1'b0;
    mem_ready  = 1'b1;
    check("rnd_halted", {31'd0, halted}, 32'd1);
    check("rnd_fault", {30'd0, fault}, 32'd1);
    check("rnd_pc", pc, 32'(4 * (n + 1)));
    for (int i = 0; i < 32; i++) check($sformatf("rnd_r%0d", i), dut.r_regs[i], m_reg[i]);
    for (int i = 128; i < 160; i++) check($sformatf("rnd_mem%0d", i), mem[i], m_mem[i]);
  endtask

  // Test sequence
  initial begin
    int          cyc;
    logic [31:0] acc;
    reset      = 1'b1;
    mem_ready  = 1'b1;
    rand_ready = 1'b0;
    wr_count   = 0;
    req_cycles = 0;
    low_streak = 0;
    wr_addr    = 32'd0;
    wr_data    = 32'd0;

    add_vec(32'h00, enc_i('h08, 0, 1, 5),    4, 32'h04, 1, 32'd5);
    add_vec(32'h04, enc_i('h08, 0, 2, -3),   4, 32'h08, 2, 32'hFFFF_FFFD);
    add_vec(32'h08, enc_r('h20, 1, 2, 3),    4, 32'h0C, 3, 32'd2);
    add_vec(32'h0C, enc_r('h2A, 2, 1, 4),    4, 32'h10, 4, 32'd1);
    add_vec(32'h10, enc_i('h2B, 0, 3, 8),    4, 32'h14, -1, 32'd0);
    add_vec(32'h14, enc_i('h23, 0, 5, 8),    5, 32'h18, 5, 32'd2);
    add_vec(32'h18, enc_r('h22, 1, 2, 6),    4, 32'h1C, 6, 32'd8);
    add_vec(32'h1C, enc_r('h24, 1, 2, 7),    4, 32'h20, 7, 32'd5);
    add_vec(32'h20, enc_r('h25, 1, 2, 8),    4, 32'h24, 8, 32'hFFFF_FFFD);
    add_vec(32'h24, enc_r('h2A, 2, 0, 9),    4, 32'h28, 9, 32'd1);
    add_vec(32'h28, enc_i('h08, 0, 0, 7),    4, 32'h2C, 0, 32'd0);
    add_vec(32'h2C, enc_i('h08, 8, 10, 5),   4, 32'h30, 10, 32'd2);
    add_vec(32'h30, enc_i('h04, 1, 2, 5),    3, 32'h34, 1, 32'd5);
    add_vec(32'h34, enc_j('h10),             3, 32'h40, -1, 32'd0);
    add_vec(32'h40, enc_i('h04, 0, 0, -1),   3, 32'h40, -1, 32'd0);
    add_vec(32'h40, enc_i('h04, 0, 0, -1),   3, 32'h40, -1, 32'd0);

    // Table-driven program with ready tied high
    clear_mem();
    foreach (vecs[i]) mem[vecs[i].addr[9:2]] = vecs[i].instr;
    do_reset();
    foreach (vecs[i]) begin
      run_instr(cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
      check($sformatf("vec%0d_pc", i), pc, vecs[i].pc_after);
      if (vecs[i].reg_idx >= 0)
        check($sformatf("vec%0d_reg", i), dut.r_regs[vecs[i].reg_idx], vecs[i].reg_val);
    end
    check("sw_count", 32'(wr_count), 32'd1);
    check("sw_addr", wr_addr, 32'd8);
    check("sw_data", wr_data, 32'd2);

    // Fetch held off for three cycles, completes on the fourth
    clear_mem();
    mem[0] = enc_i('h08, 0, 1, 5);
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_req", {31'd0, mem_req}, 32'd1);
      check("stall_we", {31'd0, mem_we}, 32'd0);
      check("stall_addr", mem_addr, 32'd0);
      check("stall_pc", pc, 32'd0);
      check("stall_state", {29'd0, state}, 32'd0);
    end
    mem_ready = 1'b1;
    tick();
    check("stall_done_state", {29'd0, state}, 32'd1);
    check("stall_done_pc", pc, 32'd4);

    // Ready held low for WAIT_MAX request cycles
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < WAIT_MAX - 1; i++) tick();
    check("tmo_not_yet", {31'd0, halted}, 32'd0);
    tick();
    check("tmo_halted", {31'd0, halted}, 32'd1);
    check("tmo_fault", {30'd0, fault}, 32'd2);
    check("tmo_req", {31'd0, mem_req}, 32'd0);
    mem_ready = 1'b1;
    tick();
    tick();
    check("tmo_terminal", {29'd0, state}, 32'd7);
    check("tmo_pc", pc, 32'd0);

    // Illegal opcode 3F
    clear_mem();
    mem[0] = 32'hFC00_0000;
    do_reset();
    tick();
    tick();
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_fault", {30'd0, fault}, 32'd1);
    check("ill_pc", pc, 32'd4);

    // Misaligned lw: fault 3 and no data request
    clear_mem();
    mem[0] = enc_i('h23, 0, 1, 2);
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("mis_halted", {31'd0, halted}, 32'd1);
    check("mis_fault", {30'd0, fault}, 32'd3);
    check("mis_req_cycles", 32'(req_cycles), 32'd1);
    check("mis_r1", dut.r_regs[1], 32'd0);

    // Reset during a held store request
    clear_mem();
    mem[0] = enc_i('h08, 0, 3, 9);
    mem[1] = enc_i('h2B, 0, 3, 8);
    do_reset();
    run_instr(cyc);
    check("rsw_r3", dut.r_regs[3], 32'd9);
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    check("rsw_state", {29'd0, state}, 32'd3);
    check("rsw_we", {31'd0, mem_we}, 32'd1);
    check("rsw_addr", mem_addr, 32'd8);
    check("rsw_wdata", mem_wdata, 32'd9);
    check("rsw_pc", pc, 32'd8);
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rsw_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    acc = 32'd0;
    for (int i = 0; i < 32; i++) acc = acc | dut.r_regs[i];
    check("rsw_no_write", 32'(wr_count), 32'd0);
    check("rsw_pc_reset", pc, 32'd0);
    check("rsw_regs_zero", acc, 32'd0);
    check("rsw_state_fetch", {29'd0, state}, 32'd0);
    reset = 1'b0;
    #1;
    check("rsw_req_rise", {31'd0, mem_req}, 32'd1);
    check("rsw_fetch_addr", mem_addr, 32'd0);
    check("rsw_fetch_we", {31'd0, mem_we}, 32'd0);

    // Random programs with random ready stalls against the reference model
    for (int t = 0; t < 3; t++) run_random(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
